// File: rtl/spi_proto_pkg.sv
// Shared SPI frame protocol definitions: opcodes, frame field offsets and
// the frame FSM state encoding.
package spi_proto_pkg;

  localparam logic [7:0] OP_INIT = 8'h01;
  localparam logic [7:0] OP_WR   = 8'h02;
  localparam logic [7:0] OP_RD   = 8'h03;
  localparam logic [7:0] OP_POLL = 8'h04;

  localparam int OPC_LSB   = 0;
  localparam int OPC_W     = 8;
  localparam int WDATA_LSB = 8;
  localparam int WDATA_W   = 16;
  localparam int ADDR_LSB  = 24;
  localparam int REPLY_W   = 24;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXEC    = 2'd1,
    ST_RDWAIT  = 2'd2,
    ST_RELEASE = 2'd3
  } frame_state_e;

  function automatic logic is_known_op(input logic [7:0] op);
    case (op)
      OP_INIT, OP_WR, OP_RD, OP_POLL: is_known_op = 1'b1;
      default:                        is_known_op = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant of the first requester at
// or after the pointer; the pointer moves past the winner when advanced.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] gnt
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr_q;
  logic [PW-1:0] ptr_d;
  logic [N-1:0]  hi_mask;
  logic [N-1:0]  sel;
  logic [PW-1:0] win_idx;

  // Prefer requesters at/after the pointer; fall back to the lowest one (wrap).
  always_comb begin
    hi_mask = '0;
    win_idx = '0;
    for (int i = 0; i < N; i++) begin
      hi_mask[i] = (i >= int'(ptr_q));
    end
    if ((req & hi_mask) != '0) begin
      sel = req & hi_mask;
    end else begin
      sel = req;
    end
    gnt = sel & (~sel + N'(1));
    for (int i = 0; i < N; i++) begin
      win_idx = win_idx | (PW'(i) & {PW{gnt[i]}});
    end
    if (advance && (req != '0)) begin
      if (win_idx == PW'(N - 1)) begin
        ptr_d = '0;
      end else begin
        ptr_d = win_idx + PW'(1);
      end
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Pointer register.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/spi_cmd_scheduler.sv
// SPI slave frame consumer: decodes host commands onto the config bus and
// shares the single reply slot between register read replies and stream sources.
module spi_cmd_scheduler
  import spi_proto_pkg::*;
#(
  parameter int N_SRC = 4,
  parameter int AW    = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rd_data_avail,
  input  logic [31:0]           rd_data,
  output logic                  rd_ack,
  input  logic                  wr_buffer_free,
  output logic                  wr_en,
  output logic [23:0]           wr_data,
  output logic                  cfg_we,
  output logic                  cfg_re,
  output logic [AW-1:0]         cfg_addr,
  output logic [15:0]           cfg_wdata,
  input  logic [15:0]           cfg_rdata,
  input  logic [N_SRC-1:0]      src_req,
  input  logic [24*N_SRC-1:0]   src_data,
  output logic [N_SRC-1:0]      src_gnt,
  output logic [7:0]            bad_op_cnt
);

  frame_state_e         state_q, state_d;
  logic [OPC_W-1:0]     op_q, op_d;
  logic                 rd_ack_q, rd_ack_d;
  logic                 cfg_we_q, cfg_we_d;
  logic                 cfg_re_q, cfg_re_d;
  logic [AW-1:0]        cfg_addr_q, cfg_addr_d;
  logic [WDATA_W-1:0]   cfg_wdata_q, cfg_wdata_d;
  logic [7:0]           bad_op_cnt_q, bad_op_cnt_d;
  logic                 reply_pend_q, reply_pend_d;
  logic [REPLY_W-1:0]   reply_buf_q, reply_buf_d;
  logic                 wr_en_q, wr_en_d;
  logic [REPLY_W-1:0]   wr_data_q, wr_data_d;
  logic [N_SRC-1:0]     src_gnt_q, src_gnt_d;

  logic [OPC_W-1:0]     rx_op_s;
  logic                 send_ok_s;
  logic                 arb_adv_s;
  logic [N_SRC-1:0]     arb_gnt_s;
  logic [REPLY_W-1:0]   src_word_s;

  rr_arbiter #(.N(N_SRC)) u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (src_req),
    .advance (arb_adv_s),
    .gnt     (arb_gnt_s)
  );

  // Word of the currently winning stream source.
  always_comb begin
    src_word_s = '0;
    for (int i = 0; i < N_SRC; i++) begin
      src_word_s = src_word_s | (src_data[24*i +: 24] & {24{arb_gnt_s[i]}});
    end
  end

  // Next-state logic for the frame FSM, config strobes and reply slot.
  always_comb begin
    rx_op_s      = rd_data[OPC_LSB +: OPC_W];
    state_d      = state_q;
    op_d         = op_q;
    rd_ack_d     = 1'b0;
    cfg_we_d     = 1'b0;
    cfg_re_d     = 1'b0;
    cfg_addr_d   = cfg_addr_q;
    cfg_wdata_d  = cfg_wdata_q;
    bad_op_cnt_d = bad_op_cnt_q;
    reply_pend_d = reply_pend_q;
    reply_buf_d  = reply_buf_q;
    wr_en_d      = 1'b0;
    wr_data_d    = wr_data_q;
    src_gnt_d    = '0;
    arb_adv_s    = 1'b0;

    // The wr_en_q guard keeps reply strobes at least one idle cycle apart.
    send_ok_s = wr_buffer_free && !wr_en_q;
    if (send_ok_s && reply_pend_q) begin
      wr_en_d      = 1'b1;
      wr_data_d    = reply_buf_q;
      reply_pend_d = 1'b0;
    end else if (send_ok_s && (src_req != '0)) begin
      wr_en_d   = 1'b1;
      wr_data_d = src_word_s;
      src_gnt_d = arb_gnt_s;
      arb_adv_s = 1'b1;
    end else begin
      wr_en_d = 1'b0;
    end

    // Strobes are decoded on frame acceptance so they are visible during EXEC.
    case (state_q)
      ST_IDLE: begin
        if (rd_data_avail) begin
          op_d     = rx_op_s;
          rd_ack_d = 1'b1;
          state_d  = ST_EXEC;
          if (rx_op_s == OP_WR) begin
            cfg_we_d    = 1'b1;
            cfg_addr_d  = rd_data[ADDR_LSB +: AW];
            cfg_wdata_d = rd_data[WDATA_LSB +: WDATA_W];
          end else if (rx_op_s == OP_RD) begin
            cfg_re_d   = 1'b1;
            cfg_addr_d = rd_data[ADDR_LSB +: AW];
          end else begin
            cfg_we_d = 1'b0;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_EXEC: begin
        if (op_q == OP_RD) begin
          state_d = ST_RDWAIT;
        end else begin
          state_d = ST_RELEASE;
        end
        if (!is_known_op(op_q) && (bad_op_cnt_q != 8'hFF)) begin
          bad_op_cnt_d = bad_op_cnt_q + 8'd1;
        end else begin
          bad_op_cnt_d = bad_op_cnt_q;
        end
      end
      ST_RDWAIT: begin
        // A newer read overrides whatever reply is still waiting.
        reply_buf_d  = {cfg_addr_q, cfg_rdata};
        reply_pend_d = 1'b1;
        state_d      = ST_RELEASE;
      end
      ST_RELEASE: begin
        if (!rd_data_avail) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RELEASE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      op_q         <= '0;
      rd_ack_q     <= 1'b0;
      cfg_we_q     <= 1'b0;
      cfg_re_q     <= 1'b0;
      cfg_addr_q   <= '0;
      cfg_wdata_q  <= '0;
      bad_op_cnt_q <= 8'h00;
      reply_pend_q <= 1'b0;
      reply_buf_q  <= '0;
      wr_en_q      <= 1'b0;
      wr_data_q    <= '0;
      src_gnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      rd_ack_q     <= rd_ack_d;
      cfg_we_q     <= cfg_we_d;
      cfg_re_q     <= cfg_re_d;
      cfg_addr_q   <= cfg_addr_d;
      cfg_wdata_q  <= cfg_wdata_d;
      bad_op_cnt_q <= bad_op_cnt_d;
      reply_pend_q <= reply_pend_d;
      reply_buf_q  <= reply_buf_d;
      wr_en_q      <= wr_en_d;
      wr_data_q    <= wr_data_d;
      src_gnt_q    <= src_gnt_d;
    end
  end

  assign rd_ack     = rd_ack_q;
  assign cfg_we     = cfg_we_q;
  assign cfg_re     = cfg_re_q;
  assign cfg_addr   = cfg_addr_q;
  assign cfg_wdata  = cfg_wdata_q;
  assign bad_op_cnt = bad_op_cnt_q;
  assign wr_en      = wr_en_q;
  assign wr_data    = wr_data_q;
  assign src_gnt    = src_gnt_q;

endmodule
